// File: rtl/uart_rx_os.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_rx_os                                                 |
// | Description : Oversampling UART receiver with mid-bit sampling, start    |
// |               glitch rejection, framing check and optional parity check  |
// |               (enabled by defining UART_RX_PARITY_EN).                   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module uart_rx_os #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ena,
    input  logic                 Bit_in,
    output logic [DATA_BITS-1:0] out,
    output logic                 data_valid,
    output logic                 bussy,
    output logic                 frame_err,
    output logic                 parity_err
);

    localparam int c_cnt_w = $clog2(CLKS_PER_BIT);
    localparam int c_bit_w = $clog2(DATA_BITS + 1);

    localparam logic [c_cnt_w-1:0] c_mid       = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_cnt_w-1:0] c_last      = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_bit_w-1:0] c_data_last = c_bit_w'(DATA_BITS - 1);
    localparam logic [c_bit_w-1:0] c_stop_last = c_bit_w'(STOP_BITS - 1);
    localparam logic               c_par_odd   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_sync1;
    logic                 r_rx_s;
    logic                 r_armed;
    logic [c_cnt_w-1:0]   r_baud;
    logic [c_bit_w-1:0]   r_bitcnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_out;
    logic                 r_valid;
    logic                 r_ferr;
    logic                 r_ferr_acc;

    logic w_mid_tick;
    logic w_bit_tick;
    logic w_start;
    logic w_shift;
    logic w_par_smp;
    logic w_stop_smp;
    logic w_done;
    logic w_cnt_clr;
    logic w_bit_inc;
    logic w_bit_clr;

    assign w_mid_tick = (r_baud == c_mid);
    assign w_bit_tick = (r_baud == c_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= Bit_in;
            r_rx_s  <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_shift     = 1'b0;
        w_par_smp   = 1'b0;
        w_stop_smp  = 1'b0;
        w_done      = 1'b0;
        w_cnt_clr   = 1'b0;
        w_bit_inc   = 1'b0;
        w_bit_clr   = 1'b0;
        if (!ena) begin
            w_state_nxt = S_IDLE;
            w_cnt_clr   = 1'b1;
            w_bit_clr   = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_cnt_clr = 1'b1;
                    w_bit_clr = 1'b1;
                    // Only a fresh falling edge starts a frame, never a held-low line
                    if (r_armed && !r_rx_s) begin
                        w_state_nxt = S_START;
                        w_start     = 1'b1;
                    end
                end
                S_START: begin
                    if (w_mid_tick) begin
                        w_cnt_clr   = 1'b1;
                        w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_bit_tick) begin
                        w_cnt_clr = 1'b1;
                        w_shift   = 1'b1;
                        if (r_bitcnt == c_data_last) begin
                            w_bit_clr   = 1'b1;
`ifdef UART_RX_PARITY_EN
                            w_state_nxt = S_PARITY;
`else
                            w_state_nxt = S_STOP;
`endif
                        end else begin
                            w_bit_inc = 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (w_bit_tick) begin
                        w_cnt_clr   = 1'b1;
                        w_par_smp   = 1'b1;
                        w_state_nxt = S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (w_bit_tick) begin
                        w_cnt_clr  = 1'b1;
                        w_stop_smp = 1'b1;
                        if (r_bitcnt == c_stop_last) begin
                            w_done      = 1'b1;
                            w_bit_clr   = 1'b1;
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_bit_inc = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_baud   <= '0;
            r_bitcnt <= '0;
        end else begin
            r_baud <= w_cnt_clr ? '0 : r_baud + 1'b1;
            if (w_bit_clr) begin
                r_bitcnt <= '0;
            end else if (w_bit_inc) begin
                r_bitcnt <= r_bitcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift    <= '0;
            r_out      <= '0;
            r_valid    <= 1'b0;
            r_ferr     <= 1'b0;
            r_ferr_acc <= 1'b0;
            r_armed    <= 1'b1;
        end else begin
            r_valid <= w_done;
            if (w_start) begin
                r_ferr_acc <= 1'b0;
            end else if (w_stop_smp && !r_rx_s) begin
                r_ferr_acc <= 1'b1;
            end
            if (w_shift) begin
                r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};
            end
            if (w_done) begin
                r_out  <= r_shift;
                r_ferr <= r_ferr_acc | ~r_rx_s;
            end
            // A frame ending on a low line must see the line high before re-arming
            if (w_start || (w_done && !r_rx_s)) begin
                r_armed <= 1'b0;
            end else if (r_rx_s) begin
                r_armed <= 1'b1;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_perr;
    logic r_perr_acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perr     <= 1'b0;
            r_perr_acc <= 1'b0;
        end else begin
            if (w_start) begin
                r_perr_acc <= 1'b0;
            end else if (w_par_smp) begin
                r_perr_acc <= r_rx_s ^ (^r_shift) ^ c_par_odd;
            end
            if (w_done) begin
                r_perr <= r_perr_acc;
            end
        end
    end

    assign parity_err = r_perr;
`else
    // No parity stage: the flag is constant and PARITY_ODD has no effect
    assign parity_err = 1'b0 & c_par_odd & w_par_smp;
`endif

    assign out        = r_out;
    assign data_valid = r_valid;
    assign frame_err  = r_ferr;
    assign bussy      = (r_state != S_IDLE);

endmodule
`default_nettype wire
